// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the ROM, buffers words in a prefetch FIFO.
// Optional build macro FETCH_STATS_EN adds push and full-stall counters.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          MEM_WORDS  = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          rom_read_enable,
    output logic [31:0]                   rom_addr,
    input  logic [31:0]                   rom_inst,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst_data,
    output logic [31:0]                   inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          fetch_fault,
    output logic [1:0]                    state_dbg
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]                   stat_fetched,
    output logic [31:0]                   stat_stall
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fetch_pc_q;
    logic               fault_q;
    logic [CNT_W-1:0]   count_q;
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [31:0]        data_mem [FIFO_DEPTH];
    logic [31:0]        pc_mem   [FIFO_DEPTH];

    logic               redirect_take;
    logic               push;
    logic               pop;
    logic               out_of_range;
    logic [31:0]        push_word;

    // Handshake: the head transfers on a rising edge where inst_valid and inst_ready are both high.
    // A redirect accepted on that edge wins: the pop and any push are discarded with the flush.
    assign redirect_take = redirect_valid && (state_q != S_IDLE);
    assign push          = (state_q == S_FETCH) && (count_q < DEPTH_C) && !redirect_valid;
    assign pop           = inst_valid && inst_ready && !redirect_take;
    assign out_of_range  = {2'b00, fetch_pc_q[31:2]} >= 32'(MEM_WORDS);
    assign push_word     = out_of_range ? NOP : rom_inst;

    assign rom_read_enable = push;
    assign rom_addr        = fetch_pc_q;
    assign inst_valid      = (count_q != '0);
    assign inst_data       = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc         = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign fifo_count      = count_q;
    assign fetch_fault     = fault_q;
    assign state_dbg       = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH,
            S_HALT:  if (redirect_valid)
                         state_d = (redirect_pc[1:0] != 2'b00) ? S_HALT : S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_take) begin
                fetch_pc_q <= redirect_pc;
                fault_q    <= (redirect_pc[1:0] != 2'b00);
                count_q    <= '0;
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
            end else begin
                if (push) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                    wr_ptr_q   <= wr_ptr_q + 1'b1;
                end
                if (pop)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= push_word;
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= 32'h0;
            stat_stall   <= 32'h0;
        end else begin
            if (push)
                stat_fetched <= stat_fetched + 32'd1;
            if ((state_q == S_FETCH) && (count_q == DEPTH_C))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: streaming, backpressure, redirects, ROM boundary, faults, reset.
module tb_inst_fetch_ctrl;
    logic        clk;
    logic        rst_n;
    logic        rom_read_enable;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;
    logic        fetch_fault;
    logic [1:0]  state_dbg;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch_ctrl #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(4),
        .MEM_WORDS (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_read_enable(rom_read_enable),
        .rom_addr       (rom_addr),
        .rom_inst       (rom_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .fifo_count     (fifo_count),
        .fetch_fault    (fetch_fault),
        .state_dbg      (state_dbg)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_stall     (stat_stall)
`endif
    );

    // ROM image: word i holds 32'h1000_0000 + i
    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [31:0] data);
        check({tag, " valid"}, {31'b0, inst_valid}, 32'd1);
        check({tag, " pc"}, inst_pc, pc);
        check({tag, " data"}, inst_data, data);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        rst_n          = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // reset state
        #1;
        check("rst inst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst rom_re", {31'b0, rom_read_enable}, 32'd0);
        check("rst inst_data", inst_data, 32'h0);
        check("rst inst_pc", inst_pc, 32'h0);
        check("rst count", {29'b0, fifo_count}, 32'd0);
        check("rst fault", {31'b0, fetch_fault}, 32'd0);
        check("rst rom_addr", rom_addr, 32'h0);
        check("rst state", {30'b0, state_dbg}, 32'd0);
        step();
        step();
        #3 rst_n = 1'b1;
        inst_ready = 1'b1;

        // edge 1: IDLE -> FETCH, nothing buffered yet
        step();
        check("idle->fetch valid", {31'b0, inst_valid}, 32'd0);
        check("fetch rom_re", {31'b0, rom_read_enable}, 32'd1);
        check("fetch state", {30'b0, state_dbg}, 32'd1);

        // streaming with inst_ready held high
        step();
        check_head("stream0", 32'h0, 32'h1000_0000);
        check("stream0 count", {29'b0, fifo_count}, 32'd1);
        for (int i = 1; i < 6; i++) begin
            step();
            check_head("stream", 32'(4 * i), 32'h1000_0000 + 32'(i));
            check("stream count", {29'b0, fifo_count}, 32'd1);
        end

        // asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        check("async rst valid", {31'b0, inst_valid}, 32'd0);
        check("async rst count", {29'b0, fifo_count}, 32'd0);
        check("async rst rom_re", {31'b0, rom_read_enable}, 32'd0);
        check("async rst rom_addr", rom_addr, 32'h0);
        check("async rst inst_pc", inst_pc, 32'h0);
        check("async rst state", {30'b0, state_dbg}, 32'd0);
`ifdef FETCH_STATS_EN
        check("async rst stat_fetched", stat_fetched, 32'h0);
        check("async rst stat_stall", stat_stall, 32'h0);
`endif
        inst_ready = 1'b0;
        step();
        #3 rst_n = 1'b1;

        // backpressure: fill to depth 4
        for (int i = 0; i < 10; i++)
            step();
        check("full count", {29'b0, fifo_count}, 32'd4);
        check("full rom_re", {31'b0, rom_read_enable}, 32'd0);
        check("full rom_addr", rom_addr, 32'h10);
        check_head("full head", 32'h0, 32'h1000_0000);
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, 32'd4);
        check("stat_stall", stat_stall, 32'd5);
`endif

        // drain: first pop from full gets no refill that cycle
        inst_ready = 1'b1;
        step();
        check_head("drain1", 32'h4, 32'h1000_0001);
        check("drain1 count", {29'b0, fifo_count}, 32'd3);
        step();
        check_head("drain2", 32'h8, 32'h1000_0002);
        check("drain2 count", {29'b0, fifo_count}, 32'd3);
        step();
        check_head("drain3", 32'hC, 32'h1000_0003);
        step();
        check_head("drain4", 32'h10, 32'h1000_0004);
        check("drain4 count", {29'b0, fifo_count}, 32'd3);

        // redirect with 3 entries and inst_ready=1
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        #1;
        check("redir cycle rom_re", {31'b0, rom_read_enable}, 32'd0);
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("redir flush valid", {31'b0, inst_valid}, 32'd0);
        check("redir flush count", {29'b0, fifo_count}, 32'd0);
        check("redir rom_addr", rom_addr, 32'h40);
        check("redir rom_re", {31'b0, rom_read_enable}, 32'd1);
        step();
        check_head("redir target", 32'h40, 32'h1000_0010);
        check("redir target count", {29'b0, fifo_count}, 32'd1);

        // ROM upper boundary
        redirect_to(32'h3F8);
        check("bound flush valid", {31'b0, inst_valid}, 32'd0);
        step();
        check_head("bound 3f8", 32'h3F8, 32'h1000_00FE);
        step();
        check_head("bound 3fc", 32'h3FC, 32'h1000_00FF);
        step();
        check_head("bound 400", 32'h400, 32'h0000_0013);
        step();
        check_head("bound 404", 32'h404, 32'h0000_0013);

        // misaligned redirect halts fetch
        redirect_to(32'h22);
        check("halt fault", {31'b0, fetch_fault}, 32'd1);
        check("halt valid", {31'b0, inst_valid}, 32'd0);
        check("halt rom_re", {31'b0, rom_read_enable}, 32'd0);
        check("halt state", {30'b0, state_dbg}, 32'd2);
        check("halt rom_addr", rom_addr, 32'h22);
        step();
        step();
        check("halt hold fault", {31'b0, fetch_fault}, 32'd1);
        check("halt hold valid", {31'b0, inst_valid}, 32'd0);
        check("halt hold count", {29'b0, fifo_count}, 32'd0);
        redirect_to(32'h20);
        check("unhalt fault", {31'b0, fetch_fault}, 32'd0);
        check("unhalt valid", {31'b0, inst_valid}, 32'd0);
        check("unhalt state", {30'b0, state_dbg}, 32'd1);
        step();
        check_head("unhalt target", 32'h20, 32'h1000_0008);

        // PC wraps modulo 2^32
        redirect_to(32'hFFFF_FFFC);
        step();
        check_head("wrap top", 32'hFFFF_FFFC, 32'h0000_0013);
        step();
        check_head("wrap zero", 32'h0, 32'h1000_0000);

        // redirect during IDLE is ignored
        #3 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        #1;
        check("idle state", {30'b0, state_dbg}, 32'd0);
        step();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        check("idle redir state", {30'b0, state_dbg}, 32'd1);
        check("idle redir rom_addr", rom_addr, 32'h0);
        check("idle redir fault", {31'b0, fetch_fault}, 32'd0);
        step();
        check_head("idle redir head", 32'h0, 32'h1000_0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
